instr_fetch_unit: RTL and testbench

- Owns the program counter and sequences instruction fetches from instruction memory.
- Presents one instruction at a time to decode through a valid/accept handshake.
- Applies jump and branch redirects from execute.
- Sits between the instruction memory port and the decode stage, and is the consumer of the PC-increment path.

---
 rtl/instr_fetch_unit.sv | 100 ++++++++++
 tb/tb_instr_fetch_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Owns the program counter and sequences instruction fetches. It issues one
// request at a time to instruction memory. It holds each fetched word for
// decode until decode accepts it. It applies jump/branch redirects from execute.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_req/imem_addr  fetch request and address (current PC), from state/PC only
//   imem_ready/rdata    memory response, valid in the same cycle as ready
//   instr_valid/instr/instr_pc  registered instruction presented to decode
//   instr_accept, stall decode handshake; stall blocks acceptance
//   jump/jump_target, branch_taken/branch_target  redirects (jump has priority)
//   addr_err            one-cycle pulse after a redirect to a misaligned target
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_accept,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        addr_err
);

    typedef enum logic [1:0] {StBoot, StFetch, StHold} state_t;

    state_t      state;
    logic [31:0] pc;
    logic        redirect;
    logic [31:0] target_raw;
    logic [31:0] target;

    always_comb begin
        redirect   = jump | branch_taken;
        target_raw = jump ? jump_target : branch_target;
        target     = {target_raw[31:2], 2'b00};
    end

    // Memory-side outputs depend only on registers, never on inputs.
    assign imem_req  = (state == StFetch);
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StBoot;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
            addr_err    <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            case (state)
                StBoot: begin
                    // Redirects are ignored until the first fetch is issued.
                    state <= StFetch;
                end
                StFetch: begin
                    if (redirect) begin
                        // Abandon the pending request; any returned data is dropped.
                        pc       <= target;
                        addr_err <= |target_raw[1:0];
                    end else if (imem_ready) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        state       <= StHold;
                    end
                end
                StHold: begin
                    if (redirect) begin
                        // Held instruction is from the old path: drop it even if accepted.
                        instr_valid <= 1'b0;
                        pc          <= target;
                        addr_err    <= |target_raw[1:0];
                        state       <= StFetch;
                    end else if (instr_accept && !stall) begin
                        instr_valid <= 1'b0;
                        pc          <= pc + 32'd4;
                        state       <= StFetch;
                    end
                end
                default: begin
                    state <= StBoot;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit. Expected instructions are queued
// when a fetch is issued. A monitor pops and compares on each rising instr_valid.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_accept;
    logic        stall;
    logic        jump;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        addr_err;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];   // {instr, instr_pc}
    logic        prev_valid = 1'b0;

    instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_accept (instr_accept),
        .stall        (stall),
        .jump         (jump),
        .jump_target  (jump_target),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .addr_err     (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Memory model: word derived from address; garbage when not ready.
    assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_q.push_back({mem_word(a), a});
    endtask

    // Monitor: every newly presented instruction must match the queue head.
    always @(negedge clk) begin
        if (instr_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_instr: got pc %h instr %h expected none",
                         instr_pc, instr);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("mon_instr", instr, e[63:32]);
                chk("mon_instr_pc", instr_pc, e[31:0]);
            end
        end
        prev_valid <= instr_valid;
    end

    initial begin
        rst_n = 1'b0;
        imem_ready = 1'b0;
        instr_accept = 1'b0;
        stall = 1'b0;
        jump = 1'b0;
        jump_target = 32'h0;
        branch_taken = 1'b0;
        branch_target = 32'h0;

        // Reset values
        @(negedge clk);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_addr_err", {31'b0, addr_err}, 32'd0);
        rst_n = 1'b1;
        jump = 1'b1;                  // ignored in BOOT
        jump_target = 32'h0000_8000;
        @(negedge clk);
        jump = 1'b0;
        chk("boot_req", {31'b0, imem_req}, 32'd1);
        chk("boot_addr", imem_addr, RST_PC);

        // Zero-wait memory, always accepting: 2 cycles per instruction
        imem_ready = 1'b1;
        instr_accept = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("seq_addr", imem_addr, RST_PC + 32'(4 * i));
            chk("seq_valid_lo", {31'b0, instr_valid}, 32'd0);
            push_exp(RST_PC + 32'(4 * i));
            @(negedge clk);
            chk("seq_valid_hi", {31'b0, instr_valid}, 32'd1);
            chk("seq_req_lo", {31'b0, imem_req}, 32'd0);
            @(negedge clk);
        end

        // Wait states: address stable, no capture
        imem_ready = 1'b0;
        instr_accept = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wait_addr", imem_addr, 32'h0040_000C);
            chk("wait_valid", {31'b0, instr_valid}, 32'd0);
            chk("wait_req", {31'b0, imem_req}, 32'd1);
        end
        imem_ready = 1'b1;
        push_exp(32'h0040_000C);
        @(negedge clk);

        // Stall in HOLD blocks acceptance
        stall = 1'b1;
        instr_accept = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'b0, instr_valid}, 32'd1);
            chk("stall_instr_pc", instr_pc, 32'h0040_000C);
            chk("stall_instr", instr, mem_word(32'h0040_000C));
            chk("stall_req", {31'b0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        @(negedge clk);
        chk("unstall_addr", imem_addr, 32'h0040_0010);
        chk("unstall_req", {31'b0, imem_req}, 32'd1);
        instr_accept = 1'b0;

        // Jump beats branch; ready data in the same cycle is discarded
        imem_ready = 1'b1;
        jump = 1'b1;
        jump_target = 32'h0000_1000;
        branch_taken = 1'b1;
        branch_target = 32'h0000_2000;
        @(negedge clk);
        jump = 1'b0;
        branch_taken = 1'b0;
        chk("jmp_addr", imem_addr, 32'h0000_1000);
        chk("jmp_valid", {31'b0, instr_valid}, 32'd0);
        chk("jmp_addr_err", {31'b0, addr_err}, 32'd0);
        push_exp(32'h0000_1000);
        @(negedge clk);

        // Misaligned branch in HOLD drops the held instruction
        branch_taken = 1'b1;
        branch_target = 32'h0000_3006;
        instr_accept = 1'b1;
        @(negedge clk);
        branch_taken = 1'b0;
        instr_accept = 1'b0;
        imem_ready = 1'b0;
        chk("br_addr", imem_addr, 32'h0000_3004);
        chk("br_valid", {31'b0, instr_valid}, 32'd0);
        chk("br_addr_err", {31'b0, addr_err}, 32'd1);
        @(negedge clk);
        chk("br_addr_err_end", {31'b0, addr_err}, 32'd0);

        // PC wrap at top of address space
        jump = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        @(negedge clk);
        jump = 1'b0;
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        imem_ready = 1'b1;
        instr_accept = 1'b1;
        push_exp(32'hFFFF_FFFC);
        @(negedge clk);
        imem_ready = 1'b0;
        @(negedge clk);
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        instr_accept = 1'b0;
        imem_ready = 1'b1;
        push_exp(32'h0000_0000);
        @(negedge clk);
        chk("wrap_hold_valid", {31'b0, instr_valid}, 32'd1);

        // Asynchronous reset while holding
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'b0, instr_valid}, 32'd0);
        chk("arst_addr", imem_addr, RST_PC);
        chk("arst_req", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
